// File: rtl/epu_dispatch.sv
// epu_dispatch: hands signature-verification requests to a pool of NCORE cores
// and returns their pass/fail results strictly in issue order.
//
// Ports
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   in_valid_i / in_ready_o        request handshake
//   in_sig_i/in_key_i/in_msg_i     request payload
//   in_tag_i                       request tag, returned with the result
//   core_valid_o[NCORE]            one-hot start strobe, one cycle long
//   core_ready_i[NCORE]            core idle and able to accept a start
//   core_sig_o/key_o/msg_o         shared registered payload bus to all cores
//   core_done_i/core_result_i      per-core completion pulse and pass bit
//   out_valid_o / out_ready_i      result handshake
//   out_result_o, out_tag_o        result bit and tag of the oldest request
//   busy_o                         any core owned
//   err_o                          sticky: completion from a core not waiting for one
module epu_dispatch #(
    parameter int NCORE = 4,
    parameter int SIG_W = 512,
    parameter int KEY_W = 256,
    parameter int MSG_W = 256,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [SIG_W-1:0] in_sig_i,
    input  logic [KEY_W-1:0] in_key_i,
    input  logic [MSG_W-1:0] in_msg_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic [NCORE-1:0] core_valid_o,
    input  logic [NCORE-1:0] core_ready_i,
    output logic [SIG_W-1:0] core_sig_o,
    output logic [KEY_W-1:0] core_key_o,
    output logic [MSG_W-1:0] core_msg_o,
    input  logic [NCORE-1:0] core_done_i,
    input  logic [NCORE-1:0] core_result_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int IDX_W = $clog2(NCORE);
    localparam int CNT_W = $clog2(NCORE + 1);

    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t wrap_inc(input idx_t v);
        if (int'(v) == NCORE - 1) return '0;
        return v + idx_t'(1);
    endfunction

    logic [NCORE-1:0] owned_q, owned_d;
    logic [NCORE-1:0] done_q, done_d;
    logic [NCORE-1:0] result_q, result_d;
    logic [TAG_W-1:0] tag_q [NCORE];
    logic [TAG_W-1:0] tag_d [NCORE];
    idx_t             fifo_q [NCORE];
    idx_t             fifo_d [NCORE];
    idx_t             head_q, head_d;
    idx_t             tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    idx_t             rr_q, rr_d;
    logic [NCORE-1:0] core_valid_q, core_valid_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic             err_q, err_d;

    logic [NCORE-1:0] free;
    idx_t             sel;
    idx_t             cand;
    logic             sel_found;
    logic             push;
    logic             pop;
    idx_t             head_core;

    assign free       = ~owned_q & core_ready_i;
    // Held low while reset is asserted so nothing looks acceptable during reset.
    assign in_ready_o = (|free) & ~reset_i;
    assign push       = in_valid_i & in_ready_o;

    // Round-robin: first free core at or after rr_q, wrapping at NCORE.
    always_comb begin
        sel       = '0;
        cand      = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NCORE; k++) begin
            cand = idx_t'((int'(rr_q) + k) % NCORE);
            if (!sel_found && free[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    assign head_core    = fifo_q[head_q];
    assign out_valid_o  = (count_q != '0) & done_q[head_core];
    assign out_result_o = out_valid_o & result_q[head_core];
    assign out_tag_o    = out_valid_o ? tag_q[head_core] : '0;
    assign pop          = out_valid_o & out_ready_i;

    assign core_valid_o = core_valid_q;
    assign core_sig_o   = sig_q;
    assign core_key_o   = key_q;
    assign core_msg_o   = msg_q;
    assign busy_o       = |owned_q;
    assign err_o        = err_q;

    always_comb begin
        owned_d      = owned_q;
        done_d       = done_q;
        result_d     = result_q;
        tag_d        = tag_q;
        fifo_d       = fifo_q;
        head_d       = head_q;
        tail_d       = tail_q;
        rr_d         = rr_q;
        err_d        = err_q;
        core_valid_d = '0;
        sig_d        = sig_q;
        key_d        = key_q;
        msg_d        = msg_q;

        // A completion is only legal from a core that owns a request and has
        // not reported yet; anything else is flagged and dropped.
        for (int i = 0; i < NCORE; i++) begin
            if (core_done_i[i]) begin
                if (owned_q[i] && !done_q[i]) begin
                    done_d[i]   = 1'b1;
                    result_d[i] = core_result_i[i];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // The popped core is still owned this cycle, so it cannot also be
        // the push target; it becomes selectable next cycle.
        if (pop) begin
            owned_d[head_core] = 1'b0;
            done_d[head_core]  = 1'b0;
            head_d             = wrap_inc(head_q);
        end

        if (push) begin
            core_valid_d[sel] = 1'b1;
            owned_d[sel]      = 1'b1;
            tag_d[sel]        = in_tag_i;
            fifo_d[tail_q]    = sel;
            tail_d            = wrap_inc(tail_q);
            rr_d              = wrap_inc(sel);
            sig_d             = in_sig_i;
            key_d             = in_key_i;
            msg_d             = in_msg_i;
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owned_q      <= '0;
            done_q       <= '0;
            result_q     <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rr_q         <= '0;
            err_q        <= 1'b0;
            core_valid_q <= '0;
            sig_q        <= '0;
            key_q        <= '0;
            msg_q        <= '0;
            for (int i = 0; i < NCORE; i++) begin
                tag_q[i]  <= '0;
                fifo_q[i] <= '0;
            end
        end else begin
            owned_q      <= owned_d;
            done_q       <= done_d;
            result_q     <= result_d;
            tag_q        <= tag_d;
            fifo_q       <= fifo_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rr_q         <= rr_d;
            err_q        <= err_d;
            core_valid_q <= core_valid_d;
            sig_q        <= sig_d;
            key_q        <= key_d;
            msg_q        <= msg_d;
        end
    end

endmodule

// File: tb/tb_epu_dispatch.sv
// Testbench for epu_dispatch: directed scenarios with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_epu_dispatch;

    localparam int NC = 4;
    localparam int SW = 512;
    localparam int KW = 256;
    localparam int MW = 256;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_sig = '0;
    logic [KW-1:0] in_key = '0;
    logic [MW-1:0] in_msg = '0;
    logic [TW-1:0] in_tag = '0;
    logic [NC-1:0] core_valid;
    logic [NC-1:0] core_ready = '1;
    logic [SW-1:0] core_sig;
    logic [KW-1:0] core_key;
    logic [MW-1:0] core_msg;
    logic [NC-1:0] core_done = '0;
    logic [NC-1:0] core_result = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_result;
    logic [TW-1:0] out_tag;
    logic          busy;
    logic          err;

    epu_dispatch #(.NCORE(NC), .SIG_W(SW), .KEY_W(KW), .MSG_W(MW), .TAG_W(TW)) dut (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_sig_i(in_sig), .in_key_i(in_key), .in_msg_i(in_msg), .in_tag_i(in_tag),
        .core_valid_o(core_valid), .core_ready_i(core_ready),
        .core_sig_o(core_sig), .core_key_o(core_key), .core_msg_o(core_msg),
        .core_done_i(core_done), .core_result_i(core_result),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_tag_o(out_tag),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ownership per core plus the issue order as a queue.
    bit            m_owned [NC];
    bit            m_done  [NC];
    bit            m_res   [NC];
    logic [TW-1:0] m_tag   [NC];
    int            m_ord[$];
    int            m_rr;
    bit            m_err;
    logic [NC-1:0] m_cv;
    logic [SW-1:0] m_sig;
    logic [KW-1:0] m_key;
    logic [MW-1:0] m_msg;

    // Bench-side cores for the random phase.
    bit c_busy [NC];
    int c_cnt  [NC];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            m_owned[i] = 0; m_done[i] = 0; m_res[i] = 0; m_tag[i] = '0;
            c_busy[i] = 0; c_cnt[i] = 0;
        end
        m_ord.delete();
        m_rr = 0; m_err = 0; m_cv = '0;
        m_sig = '0; m_key = '0; m_msg = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        core_done = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_sig", core_sig, 0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: pre-edge check of in_ready, model update at the edge,
    // post-edge comparison of every registered output.
    task automatic step();
        bit exp_rdy, xfer, pop, exp_ov;
        int sel;
        int c;
        #1;
        exp_rdy = 0;
        for (int i = 0; i < NC; i++)
            if (!m_owned[i] && core_ready[i]) exp_rdy = 1;
        chk("in_ready", in_ready, exp_rdy);
        xfer = in_valid && exp_rdy;
        sel = -1;
        if (xfer) begin
            for (int k = 0; k < NC; k++) begin
                int idx;
                idx = (m_rr + k) % NC;
                if (sel < 0 && !m_owned[idx] && core_ready[idx]) sel = idx;
            end
        end
        pop = (m_ord.size() > 0) && m_done[m_ord[0]] && out_ready;
        @(posedge clk);
        for (int i = 0; i < NC; i++) begin
            if (core_done[i]) begin
                if (m_owned[i] && !m_done[i]) begin
                    m_done[i] = 1;
                    m_res[i] = core_result[i];
                end else begin
                    m_err = 1;
                end
            end
        end
        if (pop) begin
            c = m_ord.pop_front();
            m_owned[c] = 0;
            m_done[c] = 0;
        end
        m_cv = '0;
        if (xfer) begin
            m_owned[sel] = 1;
            m_tag[sel] = in_tag;
            m_ord.push_back(sel);
            m_rr = (sel + 1) % NC;
            m_cv[sel] = 1'b1;
            m_sig = in_sig; m_key = in_key; m_msg = in_msg;
        end
        #1;
        exp_ov = (m_ord.size() > 0) && m_done[m_ord[0]];
        chk("core_valid", core_valid, m_cv);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_tag", out_tag, m_tag[m_ord[0]]);
            chk("out_result", out_result, m_res[m_ord[0]]);
        end
        chk("busy", busy, m_ord.size() > 0);
        chk("err", err, m_err);
        chk("core_sig", core_sig, m_sig);
        chk("core_key", core_key, m_key);
        chk("core_msg", core_msg, m_msg);
    endtask

    task automatic cores_tick();
        for (int i = 0; i < NC; i++) begin
            core_done[i] = 1'b0;
            if (m_cv[i]) begin
                c_busy[i] = 1;
                c_cnt[i] = $urandom_range(0, 6);
            end else if (c_busy[i]) begin
                if (c_cnt[i] == 0) begin
                    core_done[i] = 1'b1;
                    core_result[i] = 1'($urandom_range(0, 1));
                    c_busy[i] = 0;
                end else begin
                    c_cnt[i]--;
                end
            end
            core_ready[i] = !c_busy[i] && ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic rand_payload();
        for (int j = 0; j < SW / 32; j++) in_sig[j*32 +: 32] = $urandom();
        for (int j = 0; j < KW / 32; j++) in_key[j*32 +: 32] = $urandom();
        for (int j = 0; j < MW / 32; j++) in_msg[j*32 +: 32] = $urandom();
        in_tag = TW'($urandom());
    endtask

    initial begin
        int n;
        #1;
        do_reset();
        core_ready = '1;

        // Four back-to-back requests fill cores 0..3 in order.
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_tag = TW'(k);
            rand_payload();
            in_tag = TW'(k);
            step();
            chk("d_fill_cv", core_valid, 4'b0001 << (k - 1));
        end
        in_valid = 1'b0;
        #1;
        chk("d_fill_in_ready", in_ready, 0);

        // Completion in reverse order; nothing returns until core 0 is done.
        core_done = 4'b1000; core_result = 4'b1000; step();
        chk("d_rev_ov3", out_valid, 0);
        core_done = 4'b0100; core_result = 4'b0000; step();
        chk("d_rev_ov2", out_valid, 0);
        core_done = 4'b0010; core_result = 4'b0010; step();
        chk("d_rev_ov1", out_valid, 0);
        core_done = 4'b0001; core_result = 4'b0000; step();
        core_done = '0;
        chk("d_rev_ov0", out_valid, 1);
        chk("d_rev_tag0", out_tag, 1);
        chk("d_rev_res0", out_result, 0);

        // Backpressure: result held, nothing accepted.
        in_valid = 1'b1; in_tag = 8'd7;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("d_hold_ov", out_valid, 1);
            chk("d_hold_tag", out_tag, 1);
            chk("d_hold_res", out_result, 0);
            chk("d_hold_rdy", in_ready, 0);
            chk("d_hold_cv", core_valid, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); chk("d_pop_tag2", out_tag, 2); chk("d_pop_res2", out_result, 1);
        step(); chk("d_pop_tag3", out_tag, 3); chk("d_pop_res3", out_result, 0);
        step(); chk("d_pop_tag4", out_tag, 4); chk("d_pop_res4", out_result, 1);
        step(); chk("d_pop_empty", out_valid, 0); chk("d_pop_busy", busy, 0);
        out_ready = 1'b0;

        // Pop of core 0 and a request in the same cycle: request waits one cycle.
        for (int k = 11; k <= 14; k++) begin
            in_valid = 1'b1; in_tag = TW'(k); step();
        end
        in_valid = 1'b0;
        core_done = 4'b0001; core_result = 4'b0001; step();
        core_done = '0;
        chk("d_same_tag11", out_tag, 11);
        in_valid = 1'b1; in_tag = 8'd15; out_ready = 1'b1;
        step();
        chk("d_same_cv_wait", core_valid, 0);
        chk("d_same_rdy", in_ready, 1);
        out_ready = 1'b0;
        step();
        chk("d_same_cv0", core_valid, 4'b0001);
        in_valid = 1'b0;

        // Reset with three cores owned and the head done.
        core_done = 4'b0010; core_result = 4'b0000; step();
        core_done = '0; out_ready = 1'b1; step();
        out_ready = 1'b0;
        core_done = 4'b0100; core_result = 4'b0100; step();
        core_done = '0;
        chk("d_pre_rst_ov", out_valid, 1);
        chk("d_pre_rst_tag", out_tag, 13);
        do_reset();
        in_valid = 1'b1; in_tag = 8'd9; step();
        chk("d_post_rst_cv", core_valid, 4'b0001);
        in_valid = 1'b0;

        // Completion from an unowned core is flagged and sticky.
        core_done = 4'b0001; core_result = 4'b0001; step();
        core_done = 4'b0100; core_result = 4'b0000; step();
        core_done = '0;
        chk("d_err_set", err, 1);
        chk("d_err_ov", out_valid, 1);
        chk("d_err_tag", out_tag, 9);
        out_ready = 1'b1; step();
        out_ready = 1'b0; step();
        chk("d_err_sticky", err, 1);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < NC; i++) core_ready[i] = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_payload();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            cores_tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (m_ord.size() > 0 && n < 500) begin
            step();
            cores_tick();
            n++;
        end
        chk("drain_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/epu_dispatch.md
EPU_DISPATCH -- requirements
Module: epu_dispatch

Interface
REQ-001 Parameter NCORE, default 4, number of attached signature-verification cores (2..16).
REQ-002 Parameter SIG_W, default 512, signature width; KEY_W, default 256, public-key width; MSG_W, default 256, message-digest width.
REQ-003 Parameter TAG_W, default 8, request tag width returned with each result.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 in_valid  in  1 / in_ready  out  1  request handshake; transfer when both high.
REQ-007 in_sig  in  SIG_W / in_key  in  KEY_W / in_msg  in  MSG_W / in_tag  in  TAG_W  request payload, sampled on transfer.
REQ-008 core_valid  out  NCORE  one-hot start strobe, one per core.
REQ-009 core_ready  in  NCORE  core i idle and able to accept a start.
REQ-010 core_sig  out  SIG_W / core_key  out  KEY_W / core_msg  out  MSG_W  shared registered payload bus to all cores.
REQ-011 core_done  in  NCORE / core_result  in  NCORE  core i completion pulse and pass(1)/fail(0) bit, valid while core_done[i] high.
REQ-012 out_valid  out  1 / out_ready  in  1  result handshake; out_result  out  1, out_tag  out  TAG_W.
REQ-013 busy  out  1  any core owned; err  out  1  sticky protocol error.

Function
REQ-014 Per core: owned flag, done flag, result bit, tag register; issue-order FIFO of core indices, depth NCORE.
REQ-015 Core i is free when owned[i]=0 and core_ready[i]=1.
REQ-016 in_ready = at least one free core; driven from registered state and core_ready only, never from out_ready or in_valid.
REQ-017 Selection: round-robin over free cores starting at rr_ptr; after a transfer rr_ptr = selected index + 1 modulo NCORE.
REQ-018 On transfer in cycle t: payload registered onto core_* bus, core_valid[sel] high for exactly cycle t+1, owned[sel] set, tag stored, sel pushed to FIFO tail.
REQ-019 Back-to-back transfers allowed every cycle; core_* bus holds last payload when core_valid is all zero.
REQ-020 core_done[i] with owned[i]=1 and done[i]=0: done[i] set, result[i] latched from core_result[i].
REQ-021 core_done[i] with owned[i]=0 or done[i]=1: ignored for data, err set until reset.
REQ-022 Results returned strictly in issue order: out_valid = done[head]; out_result = result[head]; out_tag = tag[head], all registered.
REQ-023 Earliest out_valid is cycle after core_done of head core; later-issued cores completing first wait in done state.
REQ-024 Pop on out_valid & out_ready: owned[head], done[head] cleared, FIFO head advances; core becomes selectable next cycle.
REQ-025 out_valid, out_result, out_tag stable while out_valid=1 and out_ready=0.
REQ-026 Simultaneous transfer, pop and core_done in one cycle all take effect; FIFO count = count + push - pop.
REQ-027 FIFO pointers wrap modulo NCORE; FIFO cannot overflow since pushes bounded by free cores.
REQ-028 busy = OR of owned flags.

Reset
REQ-029 On reset high, immediately: in_ready=0 pending core_ready reevaluation, core_valid=0, out_valid=0, out_result=0, out_tag=0, busy=0, err=0, rr_ptr=0, FIFO empty, all flags clear, core_* bus zero.
REQ-030 Reset mid-operation discards in-flight results; subsequent core_done from earlier starts sets err; attached cores are reset externally.

Verification
REQ-031 NCORE=4, all core_ready=1, four back-to-back requests tags 1..4 -> core_valid 0001,0010,0100,1000 on consecutive cycles, then in_ready=0.
REQ-032 Cores complete in order 3,2,1,0 with results 1,0,1,0 -> outputs tag1/0? no: tag1 res0, tag2 res1, tag3 res0, tag4 res1 in tag order, tag1 one cycle after core0 done.
REQ-033 out_ready held 0 for 5 cycles with out_valid=1 -> out_valid/out_tag/out_result unchanged, no new request accepted once all cores owned.
REQ-034 core_done[2] pulsed while core 2 unowned -> err=1, out_valid unaffected, err stays 1 until reset.
REQ-035 Reset asserted with 3 cores owned and one done -> out_valid=0, busy=0 same cycle; after release, request tag 9 goes to core 0.
REQ-036 Same-cycle pop of core 0 and new request with only core 0 otherwise free -> request waits, dispatched to core 0 one cycle later.
